// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage.
// Writeback source select encodings and load funct3 codes.
package wb_pkg;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_IMM = 2'd2,
        WB_PC4 = 2'd3
    } wb_sel_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/wb_load_ext.sv
// Load data extraction: picks a byte/half of the raw load word
// and sign- or zero-extends it to XLEN.
module wb_load_ext
    import wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr,
    input  logic [XLEN-1:0] dout,
    output logic [XLEN-1:0] ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = dout[7:0];
        case (addr)
            2'd0:    byte_sel = dout[7:0];
            2'd1:    byte_sel = dout[15:8];
            2'd2:    byte_sel = dout[23:16];
            default: byte_sel = dout[31:24];
        endcase
        half_sel = addr[1] ? dout[31:16] : dout[15:0];
    end

    always_comb begin
        ext = dout;
        case (funct3)
            F3_LB:   ext = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LBU:  ext = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LH:   ext = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_LHU:  ext = {{(XLEN-16){1'b0}}, half_sel};
            F3_LW:   ext = dout;
            default: ext = dout;
        endcase
    end

endmodule

// File: rtl/wb_arbiter_stage.sv
// Writeback stage: merges the in-order pipe result with long-latency
// units onto the single regfile write port, registered by one cycle.
module wb_arbiter_stage
    import wb_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int NUM_EXT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    p_valid,
    output logic                    p_ready,
    input  logic [31:0]             p_instr,
    input  logic [XLEN-1:0]         p_pc4,
    input  logic [XLEN-1:0]         p_alu,
    input  logic [XLEN-1:0]         p_imm,
    input  logic [XLEN-1:0]         p_dout,
    input  logic [1:0]              p_wb_sel,
    input  logic [NUM_EXT-1:0]      x_valid,
    output logic [NUM_EXT-1:0]      x_ready,
    input  logic [NUM_EXT*5-1:0]    x_rd,
    input  logic [NUM_EXT*XLEN-1:0] x_data,
    output logic                    rf_we,
    output logic [4:0]              rf_waddr,
    output logic [XLEN-1:0]         rf_wdata
);

    localparam int PW = (NUM_EXT > 1) ? $clog2(NUM_EXT) : 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [4:0]      p_rd;
    logic [2:0]      p_f3;
    logic [XLEN-1:0] ld_ext;
    logic [XLEN-1:0] p_data;

    logic [PW-1:0]   ptr_q, ptr_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic            rf_we_q, rf_we_d;
    logic [4:0]      rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;

    logic            any_x;
    logic            starved;
    logic            pipe_gnt;
    logic            ext_gnt;
    logic [PW-1:0]   win;
    logic            found;
    logic [PW-1:0]   idx;
    logic [4:0]      ext_rd;
    logic [XLEN-1:0] ext_data;
    logic [NUM_EXT-1:0] x_ready_c;
    logic [4:0]      wr_rd;
    logic [XLEN-1:0] wr_data;

    logic unused_instr_bits;

    assign p_rd = p_instr[11:7];
    assign p_f3 = p_instr[14:12];
    assign unused_instr_bits = ^{p_instr[31:15], p_instr[6:0]};

    wb_load_ext #(.XLEN(XLEN)) u_load_ext (
        .funct3 (p_f3),
        .addr   (p_alu[1:0]),
        .dout   (p_dout),
        .ext    (ld_ext)
    );

    always_comb begin
        p_data = p_alu;
        case (wb_sel_e'(p_wb_sel))
            WB_ALU:  p_data = p_alu;
            WB_MEM:  p_data = ld_ext;
            WB_IMM:  p_data = p_imm;
            WB_PC4:  p_data = p_pc4;
            default: p_data = p_alu;
        endcase
    end

    // Round-robin search: lowest valid index at or after ptr, wrapping.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NUM_EXT; i++) begin
            idx = PW'((int'(ptr_q) + i) % NUM_EXT);
            if (!found && x_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        ext_rd   = x_rd[4:0];
        ext_data = x_data[XLEN-1:0];
        for (int i = 0; i < NUM_EXT; i++) begin
            if (PW'(i) == win) begin
                ext_rd   = x_rd[i*5 +: 5];
                ext_data = x_data[i*XLEN +: XLEN];
            end
        end
    end

    // A flushed pipe request is consumed but never competes for the port.
    always_comb begin
        any_x    = |x_valid;
        starved  = (starve_q == SW'(STARVE_MAX));
        pipe_gnt = p_valid && !flush && !(starved && any_x);
        ext_gnt  = any_x && !pipe_gnt;
    end

    always_comb begin
        x_ready_c = '0;
        x_ready_c[win] = ext_gnt;
        x_ready = rst_n ? x_ready_c : '0;
        p_ready = rst_n && p_valid && (flush || pipe_gnt);
    end

    always_comb begin
        ptr_d    = ptr_q;
        starve_d = starve_q;
        if (ext_gnt) begin
            starve_d = '0;
            if (int'(win) == NUM_EXT - 1) ptr_d = '0;
            else ptr_d = win + PW'(1);
        end else if (any_x && !flush && !starved) begin
            starve_d = starve_q + SW'(1);
        end
    end

    always_comb begin
        wr_rd      = pipe_gnt ? p_rd : ext_rd;
        wr_data    = pipe_gnt ? p_data : ext_data;
        rf_we_d    = (pipe_gnt || ext_gnt) && (wr_rd != 5'd0);
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (pipe_gnt || ext_gnt) begin
            rf_waddr_d = wr_rd;
            rf_wdata_d = wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q      <= '0;
            starve_q   <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            starve_q   <= starve_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_wb_arbiter_stage.sv
// Directed bench for wb_arbiter_stage: load extension, selection,
// starvation, round-robin, flush and async reset.
module tb_wb_arbiter_stage;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        p_valid;
    logic        p_ready;
    logic [31:0] p_instr;
    logic [31:0] p_pc4;
    logic [31:0] p_alu;
    logic [31:0] p_imm;
    logic [31:0] p_dout;
    logic [1:0]  p_wb_sel;
    logic [1:0]  x_valid;
    logic [1:0]  x_ready;
    logic [9:0]  x_rd;
    logic [63:0] x_data;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int n_cmp = 0;
    int n_err = 0;

    wb_arbiter_stage #(
        .XLEN       (32),
        .NUM_EXT    (2),
        .STARVE_MAX (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .p_valid  (p_valid),
        .p_ready  (p_ready),
        .p_instr  (p_instr),
        .p_pc4    (p_pc4),
        .p_alu    (p_alu),
        .p_imm    (p_imm),
        .p_dout   (p_dout),
        .p_wb_sel (p_wb_sel),
        .x_valid  (x_valid),
        .x_ready  (x_ready),
        .x_rd     (x_rd),
        .x_data   (x_data),
        .rf_we    (rf_we),
        .rf_waddr (rf_waddr),
        .rf_wdata (rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [4:0] rd, input logic [2:0] f3);
        return {17'd0, f3, rd, 7'b0000011};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0;
        p_valid = 1'b1; p_instr = mk(5'd1, 3'b000);
        p_pc4 = '0; p_alu = '0; p_imm = '0; p_dout = '0; p_wb_sel = 2'd0;
        x_valid = 2'b11; x_rd = '0; x_data = '0;
        #2;
        chk("rst_p_ready", p_ready, 0);
        chk("rst_x_ready", x_ready, 0);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_rf_wdata", rf_wdata, 0);
        p_valid = 1'b0; x_valid = 2'b00;
        step();
        rst_n = 1'b1;
        step();

        // load extension via MEM path
        p_valid = 1'b1; p_wb_sel = 2'd1;
        p_instr = mk(5'd5, 3'b000); p_alu = 32'h1000_0002; p_dout = 32'h1280_FF00;
        #1;
        chk("lb_p_ready", p_ready, 1);
        chk("lb_x_ready", x_ready, 0);
        step();
        chk("lb_we", rf_we, 1);
        chk("lb_waddr", rf_waddr, 5);
        chk("lb_wdata", rf_wdata, 32'hFFFF_FF80);
        p_instr = mk(5'd5, 3'b100);
        step();
        chk("lbu_wdata", rf_wdata, 32'h0000_0080);
        p_instr = mk(5'd6, 3'b001); p_alu = 32'h1000_0000;
        step();
        chk("lh_waddr", rf_waddr, 6);
        chk("lh_wdata", rf_wdata, 32'hFFFF_FF00);
        p_instr = mk(5'd6, 3'b101); p_alu = 32'h1000_0002;
        step();
        chk("lhu_wdata", rf_wdata, 32'h0000_1280);
        p_instr = mk(5'd6, 3'b010);
        step();
        chk("lw_wdata", rf_wdata, 32'h1280_FF00);

        // other selects
        p_instr = mk(5'd8, 3'b000); p_wb_sel = 2'd0; p_alu = 32'h1234_5678;
        step();
        chk("alu_wdata", rf_wdata, 32'h1234_5678);
        p_wb_sel = 2'd2; p_imm = 32'hDEAD_BEEF;
        step();
        chk("imm_wdata", rf_wdata, 32'hDEAD_BEEF);
        p_wb_sel = 2'd3; p_pc4 = 32'h0000_0104;
        step();
        chk("pc4_wdata", rf_wdata, 32'h0000_0104);

        // rd == 0
        p_instr = mk(5'd0, 3'b000); p_wb_sel = 2'd0; p_alu = 32'h55;
        #1;
        chk("x0_p_ready", p_ready, 1);
        step();
        chk("x0_we", rf_we, 0);
        chk("x0_wdata", rf_wdata, 32'h55);

        p_valid = 1'b0;
        step();
        chk("idle_we", rf_we, 0);

        // round-robin from ptr 0
        x_valid = 2'b11; x_rd = {5'd3, 5'd2};
        x_data = {32'hBBBB_0001, 32'hAAAA_0000};
        #1;
        chk("rr0_x_ready", x_ready, 2'b01);
        step();
        chk("rr0_we", rf_we, 1);
        chk("rr0_waddr", rf_waddr, 2);
        chk("rr0_wdata", rf_wdata, 32'hAAAA_0000);
        x_valid = 2'b10;
        #1;
        chk("rr1_x_ready", x_ready, 2'b10);
        step();
        chk("rr1_waddr", rf_waddr, 3);
        chk("rr1_wdata", rf_wdata, 32'hBBBB_0001);
        x_valid = 2'b00;

        // starvation: pipe wins 4 cycles, ext0 on the 5th
        p_valid = 1'b1; p_instr = mk(5'd7, 3'b000); p_alu = 32'h11;
        x_valid = 2'b01;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("stv_p_ready", p_ready, 1);
            chk("stv_x_ready", x_ready, 2'b00);
            step();
            chk("stv_waddr", rf_waddr, 7);
        end
        #1;
        chk("stv5_p_ready", p_ready, 0);
        chk("stv5_x_ready", x_ready, 2'b01);
        step();
        chk("stv5_we", rf_we, 1);
        chk("stv5_waddr", rf_waddr, 2);
        chk("stv5_wdata", rf_wdata, 32'hAAAA_0000);
        #1;
        chk("stv_rst_p_ready", p_ready, 1);
        chk("stv_rst_x_ready", x_ready, 2'b00);
        x_valid = 2'b00; p_valid = 1'b0;
        step();

        // flush with ext1 pending
        flush = 1'b1; p_valid = 1'b1; x_valid = 2'b10;
        x_rd = {5'd13, 5'd2};
        #1;
        chk("fl_p_ready", p_ready, 1);
        chk("fl_x_ready", x_ready, 2'b10);
        step();
        chk("fl_we", rf_we, 1);
        chk("fl_waddr", rf_waddr, 13);
        chk("fl_wdata", rf_wdata, 32'hBBBB_0001);
        x_valid = 2'b00;
        #1;
        chk("fl2_p_ready", p_ready, 1);
        step();
        chk("fl2_we", rf_we, 0);
        flush = 1'b0;

        // async reset mid-operation
        p_instr = mk(5'd4, 3'b000); p_alu = 32'h77;
        step();
        chk("pre_rst_we", rf_we, 1);
        chk("pre_rst_waddr", rf_waddr, 4);
        x_valid = 2'b11;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_we", rf_we, 0);
        chk("mid_rst_waddr", rf_waddr, 0);
        chk("mid_rst_wdata", rf_wdata, 0);
        chk("mid_rst_x_ready", x_ready, 0);
        chk("mid_rst_p_ready", p_ready, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
